rotator_sequencer: RTL

Control sequencer for one radix-2 single-delay-feedback (SDF) FFT stage and its rotator memory. It counts accepted samples within each N-point frame and drives the butterfly/rotator select `S` and the rotator index. It also marks which delay-line outputs carry difference terms needing rotation, and drains the last half-frame on request. It sits between the stage input stream and the `RotatorMemory8`-style twiddle memory plus butterfly datapath.

---
 rtl/rotator_sequencer_if.sv | 30 +++
 rtl/rotator_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rotator_sequencer_if.sv
// rotator_sequencer_if -- stage-side stream and control bundle for rotator_sequencer.
//   master : upstream/testbench side (drives in_valid, in_sof, flush)
//   slave  : sequencer side (drives in_ready, S, rot_addr, rot_en, drain,
//            out_valid, frame_done, sof_err)
// LOG2N must match the sequencer instance (rot_addr is LOG2N-1 bits).
interface rotator_sequencer_if #(
  parameter int LOG2N = 3
);
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic             flush;
  logic             S;
  logic [LOG2N-2:0] rot_addr;
  logic             rot_en;
  logic             drain;
  logic             out_valid;
  logic             frame_done;
  logic             sof_err;

  modport master (
    output in_valid, in_sof, flush,
    input  in_ready, S, rot_addr, rot_en, drain, out_valid, frame_done, sof_err
  );

  modport slave (
    input  in_valid, in_sof, flush,
    output in_ready, S, rot_addr, rot_en, drain, out_valid, frame_done, sof_err
  );
endinterface

// File: rtl/rotator_sequencer.sv
// rotator_sequencer -- control sequencer for one radix-2 SDF FFT stage.
// Counts accepted samples per N-point frame (N = 2**LOG2N), drives the
// butterfly select S and rotator index, flags difference terms that need
// rotation (rot_en), and drains the final half-frame on flush.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     in_valid/in_sof/flush in; in_ready, S, rot_addr, rot_en,
//                   drain, out_valid, frame_done, sof_err out (all registered)
// Parameters:
//   LOG2N   (>=2)   log2 of frame length
//   ROT_LAT (>=0)   rotator memory read latency; out_valid/frame_done are
//                   delayed by it so they line up with the rotator data
// Build option:
//   ROTSEQ_SOF_CHECK_EN  when defined, in_sof at a nonzero index in RUN
//                        resyncs the frame and pulses sof_err; otherwise
//                        in_sof is only looked at in IDLE.
module rotator_sequencer #(
  parameter int LOG2N   = 3,
  parameter int ROT_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  rotator_sequencer_if.slave bus
);
  localparam logic [LOG2N-1:0] LAST_IDX  = '1;
  localparam logic [LOG2N-1:0] HALF_LAST = {1'b0, {(LOG2N-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;
  logic             pend_q, pend_d;
  logic             in_ready_q, in_ready_d;
  logic             s_q, s_d;
  logic [LOG2N-2:0] rot_addr_q, rot_addr_d;
  logic             rot_en_q, rot_en_d;
  logic             drain_q, drain_d;
  logic             sof_err_q, sof_err_d;
  logic [ROT_LAT:0] vld_pipe_q, vld_pipe_d;
  logic [ROT_LAT:0] fd_pipe_q, fd_pipe_d;

  logic             accept;
  logic             proc;       // a sample (or drain slot) is emitted this cycle
  logic             fdone;      // last drain slot
  logic             resync;
  logic             prim_eff;   // primed as seen by the sample being processed
  logic [LOG2N-1:0] idx;        // index the current sample is processed as

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    primed_d   = primed_q;
    pend_d     = pend_q;
    proc       = 1'b0;
    fdone      = 1'b0;
    s_d        = 1'b0;
    rot_addr_d = '0;
    rot_en_d   = 1'b0;
    drain_d    = 1'b0;
    sof_err_d  = 1'b0;
    resync     = 1'b0;
    idx        = cnt_q;
    prim_eff   = primed_q;
    accept     = bus.in_valid & in_ready_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        primed_d = 1'b0;
        pend_d   = 1'b0;
        // Samples without SOF are swallowed; flush is meaningless here.
        if (accept && bus.in_sof) begin
          proc    = 1'b1;
          cnt_d   = LOG2N'(1);
          state_d = RUN;
        end
      end

      RUN: begin
        if (accept) begin
`ifdef ROTSEQ_SOF_CHECK_EN
          if (bus.in_sof && cnt_q != '0) begin
            resync    = 1'b1;
            idx       = '0;
            sof_err_d = 1'b1;
          end
`endif
          prim_eff   = primed_q & ~resync;
          proc       = 1'b1;
          s_d        = idx[LOG2N-1];
          rot_addr_d = idx[LOG2N-2:0];
          // Fill-half delay-line outputs are difference terms of the
          // previous frame, so only rotate once a full frame has gone in.
          rot_en_d   = ~idx[LOG2N-1] & prim_eff;
          cnt_d      = idx + LOG2N'(1);
          primed_d   = prim_eff | (idx == LAST_IDX);
          // An accept always wins over flush; the request waits for the
          // next idle slot at a frame boundary.
          pend_d     = (pend_q | bus.flush) & prim_eff;
        end else if ((bus.flush || pend_q) && primed_q && cnt_q == '0) begin
          state_d = FLUSH;
          pend_d  = 1'b0;
        end else if (bus.flush && primed_q) begin
          pend_d = 1'b1;
        end
      end

      FLUSH: begin
        proc       = 1'b1;
        drain_d    = 1'b1;
        rot_en_d   = 1'b1;
        rot_addr_d = cnt_q[LOG2N-2:0];
        cnt_d      = cnt_q + LOG2N'(1);
        if (cnt_q == HALF_LAST) begin
          fdone    = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
          primed_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != FLUSH);
  end

  // out_valid/frame_done ride a shift register ROT_LAT stages past the
  // registered control outputs.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    fd_pipe_d     = fd_pipe_q;
    vld_pipe_d[0] = proc;
    fd_pipe_d[0]  = fdone;
    for (int i = 1; i <= ROT_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      fd_pipe_d[i]  = fd_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      pend_q     <= 1'b0;
      in_ready_q <= 1'b0;
      s_q        <= 1'b0;
      rot_addr_q <= '0;
      rot_en_q   <= 1'b0;
      drain_q    <= 1'b0;
      sof_err_q  <= 1'b0;
      vld_pipe_q <= '0;
      fd_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      pend_q     <= pend_d;
      in_ready_q <= in_ready_d;
      s_q        <= s_d;
      rot_addr_q <= rot_addr_d;
      rot_en_q   <= rot_en_d;
      drain_q    <= drain_d;
      sof_err_q  <= sof_err_d;
      vld_pipe_q <= vld_pipe_d;
      fd_pipe_q  <= fd_pipe_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.S          = s_q;
  assign bus.rot_addr   = rot_addr_q;
  assign bus.rot_en     = rot_en_q;
  assign bus.drain      = drain_q;
  assign bus.sof_err    = sof_err_q;
  assign bus.out_valid  = vld_pipe_q[ROT_LAT];
  assign bus.frame_done = fd_pipe_q[ROT_LAT];
endmodule
